// File: rtl/display_pkg.sv
// Shared types and glyph table for the binary-to-BCD display stage.
// Glyphs are active-high and packed as {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic {IDLE, CONV} bcd_estado_t;

  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/binario_a_bcd_display_if.sv
// Start/result bus between the counter side (master) and the converter (slave).
interface binario_a_bcd_display_if #(
  parameter int N      = 6,
  parameter int DIGITS = 2
);

  logic                  inicio;
  logic [N-1:0]          valor;
  logic                  ocupado;
  logic                  listo;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   displays;

  modport master (
    output inicio, valor,
    input  ocupado, listo, bcd, displays
  );

  modport slave (
    input  inicio, valor,
    output ocupado, listo, bcd, displays
  );

endinterface

// File: rtl/bcd_a_siete_segmentos.sv
// One BCD digit to 7 segments; non-decimal nibbles are blanked.
module bcd_a_siete_segmentos
  import display_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digito,
  output logic [6:0] segmentos
);

  logic [6:0] glifo;

  always_comb begin
    glifo = SEG_BLANK;
    if (digito <= 4'd9) begin
      glifo = SEG_LUT[digito];
    end
  end

  assign segmentos = ACTIVE_LOW ? ~glifo : glifo;

endmodule

// File: rtl/binario_a_bcd_display.sv
// Sequential double-dabble converter: N shift cycles per value, result held in
// registered bcd until the next completed conversion, one 7-segment decoder per digit.
module binario_a_bcd_display
  import display_pkg::*;
#(
  parameter int N          = 6,
  parameter int DIGITS     = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  binario_a_bcd_display_if.slave  bus
);

  localparam int W  = 4*DIGITS + N;
  localparam int CW = $clog2(N+1);

  if (!((10**DIGITS) > (2**N - 1))) begin : g_param_check
    $error("DIGITS too small to hold 2**N-1 in decimal");
  end

  bcd_estado_t          estado_reg;
  logic [W-1:0]         sh_reg;
  logic [W-1:0]         ajustado;
  logic [W-1:0]         sh_next;
  logic [CW-1:0]        cnt_reg;
  logic                 ocupado_reg;
  logic                 listo_reg;
  logic [4*DIGITS-1:0]  bcd_reg;
  logic [7*DIGITS-1:0]  displays_w;

  // Add-3 correction on each BCD nibble (4-bit wrap, no carry), binary part untouched.
  assign ajustado[N-1:0] = sh_reg[N-1:0];
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_ajuste
    assign ajustado[N+4*gi +: 4] = (sh_reg[N+4*gi +: 4] >= 4'd5)
                                   ? sh_reg[N+4*gi +: 4] + 4'd3
                                   : sh_reg[N+4*gi +: 4];
  end

  // Shift left by one; the bit leaving the top is dropped.
  assign sh_next = W'({ajustado, 1'b0});

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_reg  <= IDLE;
      sh_reg      <= '0;
      cnt_reg     <= '0;
      ocupado_reg <= 1'b0;
      listo_reg   <= 1'b0;
      bcd_reg     <= '0;
    end else begin
      listo_reg <= 1'b0;
      case (estado_reg)
        IDLE: begin
          if (bus.inicio) begin
            sh_reg      <= {{(4*DIGITS){1'b0}}, bus.valor};
            cnt_reg     <= '0;
            ocupado_reg <= 1'b1;
            estado_reg  <= CONV;
          end
        end
        CONV: begin
          sh_reg  <= sh_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(N-1)) begin
            bcd_reg     <= sh_next[W-1:N];
            listo_reg   <= 1'b1;
            ocupado_reg <= 1'b0;
            estado_reg  <= IDLE;
          end
        end
        default: estado_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digito
    bcd_a_siete_segmentos #(
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_seg (
      .digito    (bcd_reg[4*gi +: 4]),
      .segmentos (displays_w[7*gi +: 7])
    );
  end

  assign bus.ocupado  = ocupado_reg;
  assign bus.listo    = listo_reg;
  assign bus.bcd      = bcd_reg;
  assign bus.displays = displays_w;

endmodule
